// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: pulls bytes from a first-word-fall-through UART RX FIFO,
// hunts for a SYNC byte, checks LEN, forwards LEN payload bytes on a
// valid/ready stream and verifies a trailing XOR checksum.
//
// Handshake: out_valid/out_data/out_last are presented combinationally from
// the FIFO head while in PAYLOAD; a byte transfers on a clock edge where
// out_valid && out_ready are both high. While out_ready is low the outputs
// hold (the FIFO head does not move), and out_valid never depends on
// out_ready.
module uart_rx_frame_ctrl #(
  parameter int           W         = 8,
  parameter logic [W-1:0] SYNC      = W'(8'hA5),
  parameter int           MAX_LEN   = 16,
  parameter int           TMO_TICKS = 320
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         s_tick,
  input  logic         rx_empty,
  input  logic [W-1:0] r_data,
  output logic         rd_uart,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         frame_ok,
  output logic         frame_err,
  output logic [1:0]   err_code,
  output logic [7:0]   err_cnt,
  output logic         busy
);

  localparam int TW = $clog2(TMO_TICKS + 1);

  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_t;

  // Current state is the FSM's observation point for bound checkers.
  state_t state;
  state_t state_n;

  logic [W-1:0]  rem_cnt;
  logic [W-1:0]  csum;
  logic [TW-1:0] tmo_cnt;

  logic       active;
  logic       len_bad;
  logic       tmo_hit;
  logic       ok_set;
  logic       err_set;
  logic [1:0] err_cause;

  // Reset gating keeps rd_uart low for the whole time reset is held.
  assign active  = en & reset;
  assign len_bad = (r_data == '0) || (r_data > W'(MAX_LEN));
  assign busy    = (state != ST_IDLE);

  // The edge on which the timeout count would reach TMO_TICKS. Counting only
  // happens with the FIFO empty, so a pop can never coincide with this.
  assign tmo_hit = active && (state != ST_IDLE) && rx_empty && s_tick &&
                   (tmo_cnt == TW'(TMO_TICKS - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and status-decision logic.
  always_comb begin
    state_n   = state;
    ok_set    = 1'b0;
    err_set   = 1'b0;
    err_cause = 2'b00;
    if (!active) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_uart && (r_data == SYNC)) begin
            state_n = ST_LEN;
          end
        end
        ST_LEN: begin
          if (rd_uart) begin
            if (len_bad) begin
              state_n   = ST_IDLE;
              err_set   = 1'b1;
              err_cause = ERR_LEN;
            end else begin
              state_n = ST_PAYLOAD;
            end
          end else if (tmo_hit) begin
            state_n   = ST_IDLE;
            err_set   = 1'b1;
            err_cause = ERR_TMO;
          end
        end
        ST_PAYLOAD: begin
          if (rd_uart) begin
            if (rem_cnt == W'(1)) begin
              state_n = ST_CSUM;
            end
          end else if (tmo_hit) begin
            state_n   = ST_IDLE;
            err_set   = 1'b1;
            err_cause = ERR_TMO;
          end
        end
        ST_CSUM: begin
          if (rd_uart) begin
            state_n = ST_IDLE;
            if (r_data == csum) begin
              ok_set = 1'b1;
            end else begin
              err_set   = 1'b1;
              err_cause = ERR_CSUM;
            end
          end else if (tmo_hit) begin
            state_n   = ST_IDLE;
            err_set   = 1'b1;
            err_cause = ERR_TMO;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // FIFO pop and payload stream outputs.
  always_comb begin
    rd_uart   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = r_data;
    if (active) begin
      case (state)
        ST_PAYLOAD: begin
          out_valid = ~rx_empty;
          out_last  = ~rx_empty && (rem_cnt == W'(1));
          rd_uart   = ~rx_empty & out_ready;
        end
        default: begin
          rd_uart = ~rx_empty;
        end
      endcase
    end
  end

  // Remaining-byte counter and running checksum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_cnt <= '0;
      csum    <= '0;
    end else if (rd_uart && (state == ST_LEN) && !len_bad) begin
      rem_cnt <= r_data;
      csum    <= r_data;
    end else if (rd_uart && (state == ST_PAYLOAD)) begin
      rem_cnt <= rem_cnt - W'(1);
      csum    <= csum ^ r_data;
    end
  end

  // Inter-byte timeout: counts ticks only while waiting on an empty FIFO
  // mid-frame, so a consumer stall (FIFO not empty) never advances it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (!active || rd_uart || (state_n == ST_IDLE)) begin
      tmo_cnt <= '0;
    end else if (rx_empty && s_tick) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Registered status pulses, sticky error cause and wrapping error count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
      err_cnt   <= 8'd0;
    end else begin
      frame_ok  <= ok_set;
      frame_err <= err_set;
      if (err_set) begin
        err_code <= err_cause;
        err_cnt  <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: a queue-based FWFT FIFO model feeds
// the DUT, drivers push bytes plus expected payload/status into scoreboard
// queues, and a negedge monitor pops and compares whatever the DUT emits.
module tb_uart_rx_frame_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         s_tick = 1'b0;
  logic         rx_empty = 1'b1;
  logic [W-1:0] r_data = '0;
  logic         out_ready = 1'b0;
  logic         rd_uart;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         frame_ok;
  logic         frame_err;
  logic [1:0]   err_code;
  logic [7:0]   err_cnt;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] fifo_q[$];
  logic [W:0]   exp_q[$];   // {last, data}
  logic [2:0]   st_q[$];    // 3'b000 = frame_ok, {1'b1, code} = frame_err
  logic         do_pop;
  logic         saw_valid = 1'b0;

  uart_rx_frame_ctrl #(
    .W(8), .SYNC(8'hA5), .MAX_LEN(16), .TMO_TICKS(320)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .s_tick(s_tick),
    .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .err_cnt(err_cnt), .busy(busy)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void refresh();
    rx_empty = (fifo_q.size() == 0);
    r_data   = rx_empty ? '0 : fifo_q[0];
  endfunction

  // FIFO model: advances after an edge on which rd_uart was high.
  always @(posedge clk) begin
    do_pop = rd_uart;
    #1;
    if (do_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh();
  end

  // Scoreboard monitor: compares every payload transfer and status pulse.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) saw_valid = 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_payload actual=%0h required=none", {out_last, out_data});
        end else begin
          chk("payload", {out_last, out_data}, exp_q.pop_front());
        end
      end
      if (frame_ok || frame_err) begin
        chk("ok_err_exclusive", frame_ok & frame_err, 0);
        if (st_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_status actual=ok%0d_err%0d_code%0d required=none",
                   frame_ok, frame_err, err_code);
        end else begin
          chk("status", frame_ok ? 3'b000 : {1'b1, err_code}, st_q.pop_front());
        end
      end
    end
  end

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [W-1:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  task automatic expect_byte(input logic last, input logic [W-1:0] b);
    exp_q.push_back({last, b});
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_outs"}, {rd_uart, out_valid, out_last, frame_ok, frame_err, busy}, 0);
    chk({name, "_err_code"}, err_code, 0);
    chk({name, "_err_cnt"}, err_cnt, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_reset_outputs("reset");
    fifo_q.delete();
    refresh();
    step(2);
    reset = 1'b1;
    en = 1'b1;
    step(1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || busy) && n < budget) begin
      step(1);
      n++;
    end
    chk({name, "_done"}, (fifo_q.size() == 0) && !busy, 1);
    step(2);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      step(1);
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
  endtask

  initial begin
    refresh();
    step(1);

    // Good frame.
    do_reset();
    out_ready = 1'b1;
    expect_byte(0, 8'h11); expect_byte(0, 8'h22); expect_byte(1, 8'h33);
    st_q.push_back(3'b000);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    wait_idle("good", 40);
    chk("good_err_cnt", err_cnt, 0);

    // Bad checksum.
    do_reset();
    out_ready = 1'b1;
    expect_byte(0, 8'h11); expect_byte(0, 8'h22); expect_byte(1, 8'h33);
    st_q.push_back(3'b110);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
    wait_idle("badcsum", 40);
    chk("badcsum_err_code", err_code, 2'b10);
    chk("badcsum_err_cnt", err_cnt, 1);

    // Length errors: zero and 17.
    do_reset();
    out_ready = 1'b1;
    saw_valid = 1'b0;
    st_q.push_back(3'b101);
    st_q.push_back(3'b101);
    send(8'hA5); send(8'h00); send(8'hA5); send(8'h11);
    wait_idle("len", 40);
    chk("len_err_code", err_code, 2'b01);
    chk("len_err_cnt", err_cnt, 2);
    chk("len_no_valid", saw_valid, 0);

    // Garbage then a one-byte frame, consumer stalled on the payload byte.
    do_reset();
    out_ready = 1'b0;
    expect_byte(1, 8'h7E);
    st_q.push_back(3'b000);
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    wait_valid("stall", 20);
    chk("stall_fifo_depth", fifo_q.size(), 2);
    for (int i = 0; i < 5; i++) begin
      s_tick = 1'b1;
      chk("stall_hold", {out_valid, out_last, out_data, rd_uart}, {1'b1, 1'b1, 8'h7E, 1'b0});
      step(1);
    end
    s_tick = 1'b0;
    chk("stall_busy", busy, 1);
    out_ready = 1'b1;
    wait_idle("stall", 20);
    chk("stall_err_cnt", err_cnt, 0);

    // Inter-byte timeout.
    do_reset();
    out_ready = 1'b1;
    expect_byte(0, 8'h11);
    st_q.push_back(3'b111);
    send(8'hA5); send(8'h02); send(8'h11);
    begin
      int n = 0;
      while (fifo_q.size() != 0 && n < 20) begin
        step(1);
        n++;
      end
    end
    chk("tmo_drained", fifo_q.size(), 0);
    step(2);
    chk("tmo_busy_before", busy, 1);
    for (int i = 1; i <= 320; i++) begin
      s_tick = 1'b1;
      step(1);
      s_tick = 1'b0;
      if (i == 319) begin
        chk("tmo_319_no_err", {frame_err, busy}, 2'b01);
      end
      if (i == 320) begin
        chk("tmo_320_err", {frame_err, busy, err_code}, {1'b1, 1'b0, 2'b11});
      end else begin
        step(1);
      end
    end
    step(2);
    chk("tmo_err_cnt", err_cnt, 1);

    // Reset mid-frame, then a good frame.
    do_reset();
    out_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h11);
    wait_valid("midrst", 20);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    fifo_q.delete();
    refresh();
    step(2);
    reset = 1'b1;
    out_ready = 1'b1;
    step(1);
    expect_byte(0, 8'h11); expect_byte(0, 8'h22); expect_byte(1, 8'h33);
    st_q.push_back(3'b000);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    wait_idle("midrst_good", 40);
    chk("midrst_err_cnt", err_cnt, 0);

    // Everything expected must have been seen.
    chk("payload_queue_empty", exp_q.size(), 0);
    chk("status_queue_empty", st_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
